doodle_motion_ctrl: RTL and testbench

- Parametrised player-motion controller for the platform-jump game. Clocked on clk_22 (one update per game tick).
- Integrates horizontal steering with screen wrap-around, vertical rise/hold/fall physics and platform-bump boosts into sprite coordinates for the renderer and collision logic.
- Adds over the previous controller:
  - explicit phase FSM
  - pause freeze
  - saturating arithmetic
  - configurable hold and invincibility durations
  - sticky fall-out flag for the game FSM.

---
 rtl/doodle_motion_if.sv | 30 +++
 rtl/doodle_motion_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_doodle_motion_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doodle_motion_if.sv
// rtl/doodle_motion_if.sv - game-state inputs and sprite motion outputs of the player controller
interface doodle_motion_if #(
    parameter int XW = 10,
    parameter int VW = 5
);
    logic [2:0]    state;
    logic          pause;
    logic          left;
    logic          right;
    logic [2:0]    bump;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [VW-1:0] speed;
    logic          rising;
    logic          hold;
    logic          invincible;
    logic          facing_right;
    logic [1:0]    boost;
    logic          fell;

    modport master (
        output state, pause, left, right, bump,
        input  x, y, speed, rising, hold, invincible, facing_right, boost, fell
    );

    modport slave (
        input  state, pause, left, right, bump,
        output x, y, speed, rising, hold, invincible, facing_right, boost, fell
    );
endinterface

// File: rtl/doodle_motion_ctrl.sv
// rtl/doodle_motion_ctrl.sv - player motion: steering with wrap, rise/hold/fall physics, platform boosts
module doodle_motion_ctrl #(
    parameter int XW          = 10,
    parameter int VW          = 5,
    parameter int X_STEP      = 5,
    parameter int X_MIN       = 200,
    parameter int X_MAX       = 440,
    parameter int SPRITE_W    = 39,
    parameter int X_INIT      = 235,
    parameter int Y_INIT      = 415,
    parameter int V_INIT      = 11,
    parameter int SCROLL_Y    = 240,
    parameter int Y_FLOOR     = 479,
    parameter int HOLD_AIR    = 100,
    parameter int HOLD_SPRING = 10,
    parameter int INV_TICKS   = 300,
    parameter int BOOST_MAX   = 24
) (
    input logic            clk_22,
    input logic            rst,
    doodle_motion_if.slave bus
);
    localparam logic [1:0] PH_RISE = 2'd0;
    localparam logic [1:0] PH_HOLD = 2'd1;
    localparam logic [1:0] PH_FALL = 2'd2;
    localparam logic [2:0] ST_GAME = 3'd2;

    localparam int HOLD_MAX = (HOLD_AIR > HOLD_SPRING) ? HOLD_AIR : HOLD_SPRING;
    localparam int HCW      = $clog2(HOLD_MAX + 1);
    localparam int ICW      = $clog2(INV_TICKS + 1);

    localparam logic [XW:0]   X_MIN_E  = (XW+1)'(X_MIN);
    localparam logic [XW:0]   SPR_W_E  = (XW+1)'(SPRITE_W);
    localparam logic [XW-1:0] X_MAX_C  = XW'(X_MAX);
    localparam logic [XW-1:0] X_STEP_C = XW'(X_STEP);
    localparam logic [XW-1:0] X_LWRAP  = XW'(X_MAX - X_STEP);
    localparam logic [XW-1:0] X_RWRAP  = XW'(X_MIN - SPRITE_W + X_STEP);
    localparam logic [XW-1:0] SCROLL_C = XW'(SCROLL_Y);
    localparam logic [XW-1:0] FLOOR_C  = XW'(Y_FLOOR);
    localparam logic [VW-1:0] V_MAX    = {VW{1'b1}};
    localparam logic [ICW-1:0] INV_MAX = ICW'(INV_TICKS);

    logic [XW-1:0]  x_q, x_d, y_q, y_d;
    logic [VW-1:0]  speed_q, speed_d;
    logic [1:0]     phase_q, phase_d, boost_q, boost_d;
    logic           hold_q, hold_d, inv_q, inv_d, face_q, face_d, fell_q, fell_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [ICW-1:0] inv_cnt_q, inv_cnt_d;

    logic [2:0]     bump_eff;
    logic           clear;
    logic [XW:0]    y_sum;
    logic [XW-1:0]  y_up, y_down;
    logic [VW-1:0]  green_speed, boost_speed;
    logic [HCW-1:0] hold_last;

    assign bump_eff = (bus.bump > 3'd4) ? 3'd0 : bus.bump;
    assign clear    = rst || (bus.state != ST_GAME);

    // Vertical moves clamp at the coordinate range instead of wrapping
    assign y_sum  = {1'b0, y_q} + (XW+1)'(speed_q);
    assign y_up   = (y_q >= XW'(speed_q)) ? (y_q - XW'(speed_q)) : '0;
    assign y_down = y_sum[XW] ? {XW{1'b1}} : y_sum[XW-1:0];

    assign green_speed = (y_q >= XW'(350)) ? VW'(11) : VW'(8);
    assign hold_last   = (boost_q == 2'd2) ? HCW'(HOLD_SPRING - 1) : HCW'(HOLD_AIR - 1);

    // Lower landings earn a bigger boost, in steps of two
    always_comb begin
        if (y_q >= XW'(420))      boost_speed = VW'(BOOST_MAX);
        else if (y_q >= XW'(390)) boost_speed = VW'(BOOST_MAX - 2);
        else if (y_q >= XW'(355)) boost_speed = VW'(BOOST_MAX - 4);
        else if (y_q >= XW'(320)) boost_speed = VW'(BOOST_MAX - 6);
        else if (y_q >= XW'(250)) boost_speed = VW'(BOOST_MAX - 8);
        else                      boost_speed = VW'(BOOST_MAX - 10);
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        speed_d    = speed_q;
        phase_d    = phase_q;
        boost_d    = boost_q;
        hold_d     = hold_q;
        inv_d      = inv_q;
        face_d     = face_q;
        fell_d     = fell_q;
        hold_cnt_d = hold_cnt_q;
        inv_cnt_d  = inv_cnt_q;

        if (clear) begin
            x_d        = XW'(X_INIT);
            y_d        = XW'(Y_INIT);
            speed_d    = VW'(V_INIT);
            phase_d    = PH_RISE;
            boost_d    = 2'd0;
            hold_d     = 1'b0;
            inv_d      = 1'b0;
            face_d     = 1'b1;
            fell_d     = 1'b0;
            hold_cnt_d = '0;
            inv_cnt_d  = '0;
        end else if (!bus.pause) begin
            if (bus.left) begin
                face_d = 1'b0;
                x_d    = (({1'b0, x_q} + SPR_W_E) < X_MIN_E) ? X_LWRAP : (x_q - X_STEP_C);
            end else if (bus.right) begin
                face_d = 1'b1;
                x_d    = (x_q > X_MAX_C) ? X_RWRAP : (x_q + X_STEP_C);
            end

            y_d = ((bump_eff != 3'd0) || (phase_q != PH_FALL)) ? y_up : y_down;

            if ((phase_q == PH_FALL) && (y_q > FLOOR_C)) fell_d = 1'b1;

            if (bump_eff == 3'd4) begin
                inv_d     = 1'b1;
                inv_cnt_d = '0;
            end else begin
                inv_cnt_d = (inv_cnt_q >= INV_MAX) ? inv_cnt_q : (inv_cnt_q + 1'b1);
                if (inv_cnt_d >= INV_MAX) inv_d = 1'b0;
            end

            if (bump_eff != 3'd0) begin
                phase_d    = PH_RISE;
                hold_d     = 1'b0;
                hold_cnt_d = '0;
                if ((bump_eff == 3'd1) || (bump_eff == 3'd4)) begin
                    boost_d = 2'd0;
                    speed_d = green_speed;
                end else begin
                    boost_d = (bump_eff == 3'd2) ? 2'd1 : 2'd2;
                    speed_d = boost_speed;
                end
            end else begin
                case (phase_q)
                    PH_RISE: begin
                        if (speed_q == '0) begin
                            if (boost_q != 2'd0) begin
                                phase_d    = PH_HOLD;
                                hold_d     = 1'b1;
                                hold_cnt_d = '0;
                            end else begin
                                phase_d = PH_FALL;
                                speed_d = VW'(1);
                            end
                        end else if (y_q <= SCROLL_C) begin
                            speed_d = '0;
                            if (boost_q != 2'd0) begin
                                phase_d    = PH_HOLD;
                                hold_d     = 1'b1;
                                hold_cnt_d = '0;
                            end
                        end else begin
                            speed_d = speed_q - 1'b1;
                        end
                    end
                    PH_HOLD: begin
                        speed_d = '0;
                        hold_d  = 1'b1;
                        if (hold_cnt_q == hold_last) begin
                            phase_d    = PH_FALL;
                            speed_d    = VW'(1);
                            hold_d     = 1'b0;
                            boost_d    = 2'd0;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    PH_FALL: speed_d = (speed_q == V_MAX) ? speed_q : (speed_q + 1'b1);
                    default: phase_d = PH_RISE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_22) begin
        x_q        <= x_d;
        y_q        <= y_d;
        speed_q    <= speed_d;
        phase_q    <= phase_d;
        boost_q    <= boost_d;
        hold_q     <= hold_d;
        inv_q      <= inv_d;
        face_q     <= face_d;
        fell_q     <= fell_d;
        hold_cnt_q <= hold_cnt_d;
        inv_cnt_q  <= inv_cnt_d;
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.speed        = speed_q;
    assign bus.rising       = (phase_q != PH_FALL);
    assign bus.hold         = hold_q;
    assign bus.invincible   = inv_q;
    assign bus.facing_right = face_q;
    assign bus.boost        = boost_q;
    assign bus.fell         = fell_q;
endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// tb/tb_doodle_motion_ctrl.sv - self-checking bench for doodle_motion_ctrl
module tb_doodle_motion_ctrl;
    logic clk_22 = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_22 = ~clk_22;

    doodle_motion_if #(.XW(10), .VW(5)) bus ();

    doodle_motion_ctrl dut (
        .clk_22 (clk_22),
        .rst    (rst),
        .bus    (bus)
    );

    localparam int RISE = 0, HOLDING = 1, FALL = 2;

    // Reference state in plain integers
    int m_x, m_y, m_s, m_ph, m_boost, m_face, m_fell;
    int m_hold_seen, m_since_yellow, m_shield;

    typedef struct {
        bit l;
        bit r;
        int bump;
        int ex;
        int ey;
        int es;
        int erise;
        int eface;
    } vec_t;

    vec_t tbl[13];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input int st, input bit p, input bit l, input bit rt, input int b);
        int nb, oy, os, oph, k, len;
        if (r || st != 2) begin
            m_x = 235; m_y = 415; m_s = 11; m_ph = RISE; m_boost = 0; m_face = 1; m_fell = 0;
            m_hold_seen = 0; m_since_yellow = 0; m_shield = 0;
            return;
        end
        if (p) return;
        nb  = (b >= 1 && b <= 4) ? b : 0;
        oy  = m_y;
        os  = m_s;
        oph = m_ph;
        if (l) begin
            m_face = 0;
            m_x = (m_x + 39 < 200) ? 435 : m_x - 5;
        end else if (rt) begin
            m_face = 1;
            m_x = (m_x > 440) ? 166 : m_x + 5;
        end
        if (nb != 0 || oph != FALL) m_y = imax(oy - os, 0);
        else                        m_y = imin(oy + os, 1023);
        if (oph == FALL && oy > 479) m_fell = 1;
        if (nb == 4) begin
            m_shield = 1;
            m_since_yellow = 0;
        end else begin
            m_since_yellow = imin(m_since_yellow + 1, 300);
            if (m_since_yellow >= 300) m_shield = 0;
        end
        if (nb != 0) begin
            m_ph = RISE;
            m_hold_seen = 0;
            if (nb == 1 || nb == 4) begin
                m_boost = 0;
                m_s = (oy >= 350) ? 11 : 8;
            end else begin
                m_boost = (nb == 2) ? 1 : 2;
                k = (oy >= 420) ? 0 : (oy >= 390) ? 1 : (oy >= 355) ? 2 : (oy >= 320) ? 3 : (oy >= 250) ? 4 : 5;
                m_s = 24 - 2 * k;
            end
        end else if (oph == RISE) begin
            if (os == 0 || oy <= 240) begin
                if (m_boost != 0) begin
                    m_ph = HOLDING; m_s = 0; m_hold_seen = 1;
                end else if (os == 0) begin
                    m_ph = FALL; m_s = 1;
                end else begin
                    m_s = 0;
                end
            end else begin
                m_s = os - 1;
            end
        end else if (oph == HOLDING) begin
            len = (m_boost == 2) ? 10 : 100;
            if (m_hold_seen >= len) begin
                m_ph = FALL; m_s = 1; m_boost = 0; m_hold_seen = 0;
            end else begin
                m_s = 0; m_hold_seen++;
            end
        end else begin
            m_s = imin(os + 1, 31);
        end
    endtask

    task automatic compare_model();
        chk("x", int'(bus.x), m_x);
        chk("y", int'(bus.y), m_y);
        chk("speed", int'(bus.speed), m_s);
        chk("rising", int'(bus.rising), (m_ph != FALL) ? 1 : 0);
        chk("hold", int'(bus.hold), (m_ph == HOLDING) ? 1 : 0);
        chk("invincible", int'(bus.invincible), m_shield);
        chk("facing_right", int'(bus.facing_right), m_face);
        chk("boost", int'(bus.boost), m_boost);
        chk("fell", int'(bus.fell), m_fell);
    endtask

    task automatic tick(input bit r, input int st, input bit p, input bit l, input bit rt, input int b);
        rst       = r;
        bus.state = 3'(st);
        bus.pause = p;
        bus.left  = l;
        bus.right = rt;
        bus.bump  = 3'(b);
        @(posedge clk_22);
        #1;
        model_step(r, st, p, l, rt, b);
        compare_model();
    endtask

    task automatic idle();
        tick(0, 2, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick(1, 2, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_x"}, int'(bus.x), 235);
        chk({tag, "_y"}, int'(bus.y), 415);
        chk({tag, "_speed"}, int'(bus.speed), 11);
        chk({tag, "_rising"}, int'(bus.rising), 1);
        chk({tag, "_hold"}, int'(bus.hold), 0);
        chk({tag, "_inv"}, int'(bus.invincible), 0);
        chk({tag, "_face"}, int'(bus.facing_right), 1);
        chk({tag, "_boost"}, int'(bus.boost), 0);
        chk({tag, "_fell"}, int'(bus.fell), 0);
    endtask

    initial begin
        int n, cnt, sx, sy, ss;

        tbl[0]  = '{1'b0, 1'b1, 0, 240, 404, 10, 1, 1};
        tbl[1]  = '{1'b1, 1'b0, 0, 235, 394,  9, 1, 0};
        tbl[2]  = '{1'b1, 1'b1, 0, 230, 385,  8, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 0, 230, 377,  7, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 0, 230, 370,  6, 1, 0};
        tbl[5]  = '{1'b0, 1'b0, 0, 230, 364,  5, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 0, 230, 359,  4, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 0, 230, 355,  3, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 0, 230, 352,  2, 1, 0};
        tbl[9]  = '{1'b0, 1'b0, 0, 230, 350,  1, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 0, 230, 349,  0, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 6, 230, 349,  1, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 5, 230, 350,  2, 0, 0};

        bus.state = 3'd2; bus.pause = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.bump = 3'd0;

        do_reset();
        chk_reset_values("reset");

        for (int i = 0; i < 13; i++) begin
            tick(0, 2, 0, tbl[i].l, tbl[i].r, tbl[i].bump);
            chk($sformatf("vec%0d_x", i), int'(bus.x), tbl[i].ex);
            chk($sformatf("vec%0d_y", i), int'(bus.y), tbl[i].ey);
            chk($sformatf("vec%0d_speed", i), int'(bus.speed), tbl[i].es);
            chk($sformatf("vec%0d_rising", i), int'(bus.rising), tbl[i].erise);
            chk($sformatf("vec%0d_face", i), int'(bus.facing_right), tbl[i].eface);
        end

        // Wrap-around in both directions
        n = 0;
        while (bus.x != 10'd435 && n < 20) begin
            tick(0, 2, 0, 1, 0, 0);
            n++;
        end
        chk("left_wrap_steps", n, 15);
        chk("left_wrap_x", int'(bus.x), 435);
        tick(0, 2, 0, 0, 1, 0);
        chk("right_x440", int'(bus.x), 440);
        tick(0, 2, 0, 0, 1, 0);
        chk("right_x445", int'(bus.x), 445);
        tick(0, 2, 0, 0, 1, 0);
        chk("right_wrap_x", int'(bus.x), 166);
        chk("right_wrap_face", int'(bus.facing_right), 1);

        // Aircraft boost: rise, hold for 100 ticks, then fall
        do_reset();
        tick(0, 2, 0, 0, 0, 2);
        chk("blue_y", int'(bus.y), 404);
        chk("blue_speed", int'(bus.speed), 22);
        chk("blue_boost", int'(bus.boost), 1);
        n = 0;
        while (!bus.hold && n < 50) begin
            idle();
            n++;
        end
        chk("blue_reach_hold", int'(bus.hold), 1);
        cnt = 0;
        while (bus.hold && cnt < 200) begin
            cnt++;
            idle();
        end
        chk("blue_hold_len", cnt, 100);
        chk("blue_exit_speed", int'(bus.speed), 1);
        chk("blue_exit_boost", int'(bus.boost), 0);
        chk("blue_exit_rising", int'(bus.rising), 0);
        tick(0, 2, 0, 0, 0, 1);
        chk("green_low_speed", int'(bus.speed), 8);
        chk("green_rising", int'(bus.rising), 1);

        // Shield duration and restart by a second yellow
        do_reset();
        tick(0, 2, 0, 0, 0, 4);
        chk("yellow_inv", int'(bus.invincible), 1);
        chk("yellow_speed", int'(bus.speed), 11);
        repeat (149) idle();
        chk("yellow_inv_mid", int'(bus.invincible), 1);
        tick(0, 2, 0, 0, 0, 4);
        cnt = 0;
        while (bus.invincible && cnt < 400) begin
            cnt++;
            idle();
        end
        chk("yellow_inv_len", cnt, 300);

        // Spring hold frozen by pause, then completes its 10 ticks
        do_reset();
        tick(0, 2, 0, 0, 0, 3);
        chk("orange_speed", int'(bus.speed), 22);
        chk("orange_boost", int'(bus.boost), 2);
        n = 0;
        while (!bus.hold && n < 50) begin
            idle();
            n++;
        end
        chk("orange_reach_hold", int'(bus.hold), 1);
        cnt = 0;
        repeat (3) begin
            cnt++;
            idle();
        end
        sx = int'(bus.x); sy = int'(bus.y); ss = int'(bus.speed);
        repeat (50) begin
            tick(0, 2, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            chk("pause_x", int'(bus.x), sx);
            chk("pause_y", int'(bus.y), sy);
            chk("pause_speed", int'(bus.speed), ss);
            chk("pause_hold", int'(bus.hold), 1);
        end
        while (bus.hold && cnt < 50) begin
            cnt++;
            idle();
        end
        chk("spring_hold_len", cnt, 10);

        // Free fall: saturation, no wrap, sticky fall-out flag
        do_reset();
        n = 0;
        while (!bus.fell && n < 300) begin
            idle();
            n++;
        end
        chk("fell_set", int'(bus.fell), 1);
        chk("fell_y_below_floor", (bus.y > 10'd479) ? 1 : 0, 1);
        repeat (40) idle();
        chk("fall_speed_sat", int'(bus.speed), 31);
        chk("fall_y_sat", int'(bus.y), 1023);
        chk("fell_sticky", int'(bus.fell), 1);
        tick(0, 4, 0, 0, 0, 0);
        chk_reset_values("lose");

        // Randomised traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r, p, l, rt;
            int st, b;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 4)) : 2;
            p  = ($urandom_range(0, 7) == 0);
            l  = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : 0;
            tick(r, st, p, l, rt, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
